fsm: RTL and testbench

FSM -- requirements
Module: fsm

---
 rtl/fsm_pkg.sv | 21 ++
 rtl/fsm.sv | 51 +++++
 tb/tb_fsm.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
//==============================================================================
// fsm_pkg : state encodings and Z-decode constant for the fsm block
// Revision: 1.0
//==============================================================================
`default_nettype none

package fsm_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_00 = 2'b00;
   localparam state_t ST_01 = 2'b01;
   localparam state_t ST_10 = 2'b10;
   localparam state_t ST_11 = 2'b11;

   // The one state in which the Moore output Z is asserted
   localparam state_t ST_Z_ACTIVE = ST_11;

endpackage

`default_nettype wire

// File: rtl/fsm.sv
//==============================================================================
// fsm : 4-state Moore machine driven by W, output Z asserted in state 11.
//       Optional macro FSM_STATE_OUT_EN exposes the state register on port state.
// Revision: 1.0
//==============================================================================
`default_nettype none

module fsm
   import fsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       W,
`ifdef FSM_STATE_OUT_EN
   output logic [1:0] state,
`endif
   output logic       Z
);

   state_t S;
   state_t next_s;

   always_comb begin
      next_s = S;
      case (S)
         ST_00:   next_s = W ? ST_11 : ST_10;
         ST_10:   next_s = W ? ST_00 : ST_11;
         ST_11:   next_s = W ? ST_10 : ST_01;
         ST_01:   next_s = W ? ST_00 : ST_01;
         default: next_s = ST_00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         S <= ST_00;
      end else begin
         S <= next_s;
      end
   end

   // Decoded from S alone, so reset clears Z as soon as S clears
   assign Z = (S == ST_Z_ACTIVE);

`ifdef FSM_STATE_OUT_EN
   assign state = S;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fsm.sv
//==============================================================================
// tb_fsm : scoreboard bench for fsm; stimulus pushes expected {S,Z},
//          a monitor pops and compares at each negedge or on an async probe.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       W = 1'b0;
   logic       Z;
`ifdef FSM_STATE_OUT_EN
   logic [1:0] state;
`endif

   fsm dut (
      .clk   (clk),
      .reset (reset),
      .W     (W),
`ifdef FSM_STATE_OUT_EN
      .state (state),
`endif
      .Z     (Z)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] s;
      logic       z;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   logic probe_tgl = 1'b0;

   // Monitor: consumes one expectation per negedge or per async probe
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or probe_tgl);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dut.S !== e.s || Z !== e.z) begin
               failures++;
               $display("FAIL %s: S=%b Z=%b, expected S=%b Z=%b", e.name, dut.S, Z, e.s, e.z);
            end
`ifdef FSM_STATE_OUT_EN
            checks++;
            if (state !== e.s) begin
               failures++;
               $display("FAIL %s_port: state=%b, expected %b", e.name, state, e.s);
            end
`endif
         end
      end
   end

   task automatic probe(input logic [1:0] s, input logic z, input string name);
      exp_t e;
      e.s = s; e.z = z; e.name = name;
      sb.push_back(e);
      probe_tgl = ~probe_tgl;
      #1;
   endtask

   task automatic step(input logic w, input logic [1:0] s, input logic z, input string name);
      exp_t e;
      W = w;
      e.s = s; e.z = z; e.name = name;
      sb.push_back(e);
      @(negedge clk);
      #1;
   endtask

   initial begin
      #5000;
      failures++;
      $display("FAIL timeout: simulation time=%0t, expected completion before 5000", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      W = 1'b0;
      #1 reset = 1'b1;
      #2 probe(2'b00, 1'b0, "rst_pre_edge");
      #3 probe(2'b00, 1'b0, "rst_hold_edge");
      #3 reset = 1'b0;
      #1;

      // W=0 walk from 00 into the absorbing state 01
      step(1'b0, 2'b10, 1'b0, "w0_00_10");
      step(1'b0, 2'b11, 1'b1, "w0_10_11");
      step(1'b0, 2'b01, 1'b0, "w0_11_01");
      step(1'b0, 2'b01, 1'b0, "w0_01_hold_a");
      step(1'b0, 2'b01, 1'b0, "w0_01_hold_b");

      step(1'b1, 2'b00, 1'b0, "w1_01_00");
      step(1'b1, 2'b11, 1'b1, "w1_00_11");
      step(1'b1, 2'b10, 1'b0, "w1_11_10");
      step(1'b1, 2'b00, 1'b0, "w1_10_00");
      step(1'b1, 2'b11, 1'b1, "w1_00_11_b");

      // Async reset between edges while S=11
      #2 reset = 1'b1;
      #1 probe(2'b00, 1'b0, "async_rst");
      @(posedge clk);
      #1 probe(2'b00, 1'b0, "rst_hold_w1");
      @(negedge clk);
      #1 reset = 1'b0;

      step(1'b1, 2'b11, 1'b1, "post_rst_w1");
      step(1'b0, 2'b01, 1'b0, "w0_11_01_b");

      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: pending=%0d, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
